clock_enable_gen: RTL and testbench
===================================

Name: clock_enable_gen

Overview:
Multi-channel fractional clock-enable generator. Runs on the memory/base PLL output clock (107.4/108 MHz class) and derives slower system timebases as single-cycle CE pulses: 21.48 MHz, 3.58 MHz, audio rates. It generalises fixed integer CLKDIV division to N runtime-programmable phase-accumulator channels. It also owns PLL-lock qualification: lock is synchronised, settled, and loss is handled explicitly.

Parameters:
NUM_CH, 4, number of independent CE channels (1..16)
ACC_W, 24, phase accumulator / increment width in bits (4..32)
LOCK_WAIT, 1024, cycles synchronised PLL lock must stay high before READY (>=1)

Ports:
CLK  in  1  base clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
PLL_LOCK  in  1  asynchronous PLL lock indicator
INC  in  NUM_CH*ACC_W  per-channel phase increment, channel i at [i*ACC_W +: ACC_W]
INC_WE  in  NUM_CH  per-channel load strobe for INC slice
EN  in  NUM_CH  per-channel run enable
SYNC  in  1  phase-align pulse: clears all accumulators
CE  out  NUM_CH  registered single-cycle clock-enable pulses
READY  out  1  registered; high only in RUN state

Behaviour:
- Reset (RESET=1 at an edge): state=WAIT_LOCK; sync flops, settle counter, all accumulators and increment registers =0; CE=0; READY=0. RESET dominates every other input.
- PLL_LOCK passes a 2-flop synchroniser (lock_s). Only lock_s is used.
- FSM:
  - WAIT_LOCK: lock_s=1 -> SETTLE, counter=0.
  - SETTLE: counter increments each cycle. lock_s=0 -> WAIT_LOCK (counter restarts on re-entry). Counter==LOCK_WAIT-1 and lock_s=1 -> RUN.
  - RUN: lock_s=0 -> WAIT_LOCK.
- READY = registered (state==RUN). READY rises exactly LOCK_WAIT+3 edges after the first edge that samples PLL_LOCK high, given continuous lock.
- Outside RUN: all accumulators forced to 0 and CE=0. Channels are therefore phase-aligned on entry to RUN.
- Increment registers load on INC_WE[i] in any state except reset. The new value is used from the next edge. If INC_WE coincides with an accumulation, that cycle uses the old increment.
- Accumulation, per edge in RUN with EN[i]=1: {carry, acc_i} <= acc_i + inc_i, computed at ACC_W+1 bits. CE[i] <= carry, so CE is high the cycle after the wrapping add (1-cycle latency).
- EN[i]=0: acc_i held, CE[i]=0.
- CE rate = f_CLK * inc_i / 2^ACC_W. inc_i=0 gives no CE. The maximum rate is (2^ACC_W-1)/2^ACC_W; a pulse every cycle is not reachable.
- Wrap is modulo 2^ACC_W. The residue is kept, so long-term rate is exact and jitter is at most 1 CLK.
- SYNC=1 in RUN: all acc_i <= 0 and CE <= 0 that edge; no carry is evaluated. SYNC takes priority over accumulation. SYNC outside RUN has no effect.
- Lock loss mid-run: the next edge after lock_s falls moves state to WAIT_LOCK; READY and CE go 0 that same edge. Increment registers are retained.

Test Plan:
- Bench config: ACC_W=8, LOCK_WAIT=16, NUM_CH=4.
- Lock qualification: RESET 4 cycles, PLL_LOCK=1 from edge 0 -> READY=0 through edge 18, READY=1 after edge 19; CE all 0 before READY.
- Settle abort: PLL_LOCK high 10 cycles, low 1 cycle (captured by sync), high again -> READY rises 19 edges after the second rise, never earlier.
- Integer divide: INC[0]=64, EN[0]=1, in RUN -> CE[0] high after the 4th RUN edge, then every 4 cycles exactly; 100 cycles give 25 pulses.
- Fractional rate and EN hold: INC[1]=51 (1/5.02), EN[1]=1 for 1000 RUN cycles -> 199 pulses, spacing always 5 or 6. Toggling EN[1] low for 7 cycles delays the next pulse by exactly 7.
- INC_WE collision and SYNC: INC[2]=128, then load 64 on the same edge acc wraps -> that CE still asserts; the next period is 4. Assert SYNC mid-run -> all CE 0 that cycle; ch0 next pulse 4 edges after SYNC.
- Lock loss: drop PLL_LOCK in RUN -> READY and CE go 0 within 3 edges. Restore lock -> READY after LOCK_WAIT+3; INC values preserved; ch0 pulses every 4 again.

Source files
------------

// File: rtl/clock_enable_gen.sv
// Multi-channel fractional clock-enable generator with PLL-lock qualification.
// Each channel is a phase accumulator whose carry becomes a single-cycle CE pulse.
module clock_enable_gen #(
  parameter int NUM_CH    = 4,
  parameter int ACC_W     = 24,
  parameter int LOCK_WAIT = 1024
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    PLL_LOCK,
  input  logic [NUM_CH*ACC_W-1:0] INC,
  input  logic [NUM_CH-1:0]       INC_WE,
  input  logic [NUM_CH-1:0]       EN,
  input  logic                    SYNC,
  output logic [NUM_CH-1:0]       CE,
  output logic                    READY
);

  localparam int CNT_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_WAIT - 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_SETTLE    = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic                           lock_meta_q, lock_s_q;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           ready_q, ready_d;
  logic [NUM_CH-1:0][ACC_W-1:0]   acc_q, acc_d;
  logic [NUM_CH-1:0][ACC_W-1:0]   inc_q, inc_d;
  logic [NUM_CH-1:0]              ce_q, ce_d;
  logic                           run;

  // Accumulator step at ACC_W+1 bits; the MSB is the wrap carry.
  function automatic logic [ACC_W:0] acc_step(input logic [ACC_W-1:0] acc,
                                              input logic [ACC_W-1:0] inc);
    return {1'b0, acc} + {1'b0, inc};
  endfunction

  always_ff @(posedge CLK) begin
    if (RESET) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= PLL_LOCK;
      lock_s_q    <= lock_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!lock_s_q) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!lock_s_q) begin
          state_d = ST_WAIT_LOCK;
        end
      end
      default: state_d = ST_WAIT_LOCK;
    endcase
  end

  // Treat the lock-loss edge as already outside RUN so READY and CE drop with the state.
  assign run     = (state_q == ST_RUN) && lock_s_q;
  assign ready_d = run;

  always_comb begin
    inc_d = inc_q;
    acc_d = acc_q;
    ce_d  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (INC_WE[i]) begin
        inc_d[i] = INC[i*ACC_W +: ACC_W];
      end
      if (!run || SYNC) begin
        acc_d[i] = '0;
      end else if (EN[i]) begin
        {ce_d[i], acc_d[i]} = acc_step(acc_q[i], inc_q[i]);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_WAIT_LOCK;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      ce_q    <= '0;
      acc_q   <= '0;
      inc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      ce_q    <= ce_d;
      acc_q   <= acc_d;
      inc_q   <= inc_d;
    end
  end

  assign CE    = ce_q;
  assign READY = ready_q;

endmodule

// File: tb/tb_clock_enable_gen.sv
// Directed bench for clock_enable_gen: lock qualification, rates, INC_WE, SYNC, lock loss.
module tb_clock_enable_gen;
  localparam int NUM_CH    = 4;
  localparam int ACC_W     = 8;
  localparam int LOCK_WAIT = 16;

  logic                    CLK = 1'b0;
  logic                    RESET;
  logic                    PLL_LOCK;
  logic [NUM_CH*ACC_W-1:0] INC;
  logic [NUM_CH-1:0]       INC_WE;
  logic [NUM_CH-1:0]       EN;
  logic                    SYNC;
  logic [NUM_CH-1:0]       CE;
  logic                    READY;

  int checks   = 0;
  int failures = 0;

  clock_enable_gen #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .LOCK_WAIT(LOCK_WAIT)) dut (
    .CLK(CLK), .RESET(RESET), .PLL_LOCK(PLL_LOCK), .INC(INC), .INC_WE(INC_WE),
    .EN(EN), .SYNC(SYNC), .CE(CE), .READY(READY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; PLL_LOCK = 1'b0; INC = '0; INC_WE = '0; EN = '0; SYNC = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (READY !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", READY); end
    checks++;
    if (CE !== 4'b0000) begin failures++; $display("FAIL reset_ce got=%b exp=0000", CE); end
  endtask

  task automatic test_lock_qual();
    RESET = 1'b0; PLL_LOCK = 1'b1;
    for (int e = 0; e <= 19; e++) begin
      if (e == 5) begin INC[7:0] = 8'd64; INC_WE = 4'b0001; EN = 4'b0001; end
      tick();
      INC_WE = '0;
      checks++;
      if (READY !== (e >= 19)) begin
        failures++; $display("FAIL lock_qual_ready edge=%0d got=%b exp=%b", e, READY, (e >= 19));
      end
      if (e <= 18) begin
        checks++;
        if (CE !== 4'b0000) begin failures++; $display("FAIL lock_qual_ce edge=%0d got=%b exp=0000", e, CE); end
      end
    end
  endtask

  task automatic test_int_div();
    int pulses;
    pulses = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      checks++;
      if (CE[0] !== ((k + 1) % 4 == 0)) begin
        failures++; $display("FAIL int_div_ce0 k=%0d got=%b exp=%b", k, CE[0], ((k + 1) % 4 == 0));
      end
      if (CE[0] === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 25) begin failures++; $display("FAIL int_div_count got=%0d exp=25", pulses); end
  endtask

  task automatic test_frac();
    int pulses, last;
    INC[15:8] = 8'd51; INC_WE = 4'b0010; tick(); INC_WE = '0;
    EN = 4'b0011;
    pulses = 0; last = -1;
    for (int n = 1; n <= 1000; n++) begin
      tick();
      if (CE[1] === 1'b1) begin
        pulses++;
        checks++;
        if (last < 0) begin
          if (n != 6) begin failures++; $display("FAIL frac_first got=%0d exp=6", n); end
        end else if ((n - last) < 5 || (n - last) > 6) begin
          failures++; $display("FAIL frac_spacing got=%0d exp=5or6", n - last);
        end
        last = n;
      end
    end
    checks++;
    if (pulses != 199) begin failures++; $display("FAIL frac_count got=%0d exp=199", pulses); end
    // Residue is 56 here: four more adds reach 260, so the pulse lands 7+4 edges out.
    EN = 4'b0001;
    for (int m = 1; m <= 7; m++) begin
      tick();
      checks++;
      if (CE[1] !== 1'b0) begin failures++; $display("FAIL en_hold m=%0d got=%b exp=0", m, CE[1]); end
    end
    EN = 4'b0011;
    for (int m = 1; m <= 4; m++) begin
      tick();
      checks++;
      if (CE[1] !== (m == 4)) begin failures++; $display("FAIL en_resume m=%0d got=%b exp=%b", m, CE[1], (m == 4)); end
    end
  endtask

  task automatic test_collision();
    INC[23:16] = 8'd128; INC_WE = 4'b0100; tick(); INC_WE = '0;
    EN = 4'b0111;
    tick();
    checks++;
    if (CE[2] !== 1'b0) begin failures++; $display("FAIL coll_first got=%b exp=0", CE[2]); end
    INC[23:16] = 8'd64; INC_WE = 4'b0100;
    tick();
    INC_WE = '0;
    checks++;
    if (CE[2] !== 1'b1) begin failures++; $display("FAIL coll_wrap got=%b exp=1", CE[2]); end
    for (int m = 1; m <= 4; m++) begin
      tick();
      checks++;
      if (CE[2] !== (m == 4)) begin failures++; $display("FAIL coll_period m=%0d got=%b exp=%b", m, CE[2], (m == 4)); end
    end
  endtask

  task automatic test_sync();
    logic found;
    logic [3:0] exp;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (CE[0] === 1'b1) found = 1'b1;
    end
    checks++;
    if (found !== 1'b1) begin failures++; $display("FAIL sync_wait_ce0 got=%b exp=1", found); end
    tick(); tick();
    SYNC = 1'b1;
    tick();
    SYNC = 1'b0;
    checks++;
    if (CE !== 4'b0000) begin failures++; $display("FAIL sync_ce got=%b exp=0000", CE); end
    for (int m = 1; m <= 4; m++) begin
      tick();
      exp = (m == 4) ? 4'b0101 : 4'b0000;
      checks++;
      if (CE !== exp) begin failures++; $display("FAIL sync_after m=%0d got=%b exp=%b", m, CE, exp); end
    end
  endtask

  task automatic test_lock_loss();
    logic [3:0] exp;
    PLL_LOCK = 1'b0;
    tick();
    checks++;
    if (READY !== 1'b1) begin failures++; $display("FAIL loss_ready1 got=%b exp=1", READY); end
    tick();
    checks++;
    if (READY !== 1'b1) begin failures++; $display("FAIL loss_ready2 got=%b exp=1", READY); end
    tick();
    checks++;
    if (READY !== 1'b0) begin failures++; $display("FAIL loss_ready3 got=%b exp=0", READY); end
    checks++;
    if (CE !== 4'b0000) begin failures++; $display("FAIL loss_ce got=%b exp=0000", CE); end
    tick(); tick();
    PLL_LOCK = 1'b1;
    for (int e = 0; e <= 26; e++) begin
      tick();
      checks++;
      if (READY !== (e >= 19)) begin
        failures++; $display("FAIL relock_ready edge=%0d got=%b exp=%b", e, READY, (e >= 19));
      end
      exp = (e == 22 || e == 26) ? 4'b0101 : (e == 24) ? 4'b0010 : 4'b0000;
      checks++;
      if (CE !== exp) begin failures++; $display("FAIL relock_ce edge=%0d got=%b exp=%b", e, CE, exp); end
    end
  endtask

  task automatic test_settle_abort();
    PLL_LOCK = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    for (int e = 0; e <= 30; e++) begin
      PLL_LOCK = (e != 10);
      tick();
      checks++;
      if (READY !== (e >= 30)) begin
        failures++; $display("FAIL abort_ready edge=%0d got=%b exp=%b", e, READY, (e >= 30));
      end
    end
  endtask

  task automatic test_reset_clears();
    RESET = 1'b1; PLL_LOCK = 1'b1; SYNC = 1'b0;
    INC = {4{8'd64}}; INC_WE = 4'hF;
    tick(); tick();
    checks++;
    if (READY !== 1'b0) begin failures++; $display("FAIL rst_dom_ready got=%b exp=0", READY); end
    checks++;
    if (CE !== 4'b0000) begin failures++; $display("FAIL rst_dom_ce got=%b exp=0000", CE); end
    INC_WE = '0; RESET = 1'b0;
    for (int e = 0; e <= 19; e++) begin
      tick();
      checks++;
      if (READY !== (e >= 19)) begin
        failures++; $display("FAIL rst_relock edge=%0d got=%b exp=%b", e, READY, (e >= 19));
      end
    end
    for (int m = 0; m < 8; m++) begin
      tick();
      checks++;
      if (CE !== 4'b0000) begin failures++; $display("FAIL rst_inc_zero m=%0d got=%b exp=0000", m, CE); end
    end
  endtask

  initial begin
    test_reset();
    test_lock_qual();
    test_int_div();
    test_frac();
    test_collision();
    test_sync();
    test_lock_loss();
    test_settle_abort();
    test_reset_clears();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
